// File: rtl/centroid_writeback_seq.sv
// Post-convergence writeback sequencer for the k-means core.
// Reads the final centroids one at a time from the classification block,
// writes each into the core register file, then writes a status word
// (converged flag + iteration count) and raises a level interrupt that
// stays high until the host acknowledges it.
module centroid_writeback_seq #(
    parameter int centroid_num    = 8,
    parameter int log2_cent_num   = 3,
    parameter int dataWidth       = 91,
    parameter int reg_amount      = 4,
    parameter int cent_reg_base   = 0,
    parameter int status_reg_addr = 8,
    parameter int iter_cnt_width  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      has_converged,
    input  logic [iter_cnt_width-1:0] iter_count,
    input  logic                      abort,
    output logic [log2_cent_num-1:0]  cent_sel,
    input  logic [dataWidth-1:0]      cent_data,
    output logic [reg_amount-1:0]     reg_num,
    output logic [dataWidth-1:0]      reg_wdata,
    output logic                      reg_write,
    input  logic                      reg_ready,
    output logic                      irq,
    input  logic                      irq_ack,
    output logic                      busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_STATUS = 3'd3;
    localparam logic [2:0] S_IRQ    = 3'd4;

    localparam logic [log2_cent_num-1:0] LAST_CENT = log2_cent_num'(centroid_num - 1);
    localparam logic [log2_cent_num-1:0] ONE_CENT  = log2_cent_num'(1);

    logic [2:0]                state_q,     state_d;
    logic [log2_cent_num-1:0]  cnt_q,       cnt_d;
    logic                      conv_q,      conv_d;
    logic [iter_cnt_width-1:0] iter_q,      iter_d;
    logic [log2_cent_num-1:0]  cent_sel_q,  cent_sel_d;
    logic [reg_amount-1:0]     reg_num_q,   reg_num_d;
    logic [dataWidth-1:0]      reg_wdata_q, reg_wdata_d;
    logic                      reg_write_q, reg_write_d;
    logic                      irq_q,       irq_d;
    logic                      busy_q,      busy_d;

    // Next-state and output-register logic for the writeback sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        conv_d      = conv_q;
        iter_d      = iter_q;
        cent_sel_d  = cent_sel_q;
        reg_num_d   = reg_num_q;
        reg_wdata_d = reg_wdata_q;
        reg_write_d = reg_write_q;
        irq_d       = irq_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    conv_d     = has_converged;
                    iter_d     = iter_count;
                    cnt_d      = '0;
                    cent_sel_d = '0;
                    state_d    = S_SELECT;
                end
            end
            S_SELECT: begin
                // cent_data is combinational on cent_sel, so capture it now;
                // later changes on cent_data cannot disturb the pending write.
                reg_wdata_d = cent_data;
                reg_num_d   = reg_amount'(cent_reg_base + int'(cnt_q));
                reg_write_d = 1'b1;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                if (reg_ready) begin
                    if (cnt_q == LAST_CENT) begin
                        reg_num_d   = reg_amount'(status_reg_addr);
                        reg_wdata_d = {{(dataWidth - iter_cnt_width - 1){1'b0}}, iter_q, conv_q};
                        state_d     = S_STATUS;
                    end else begin
                        reg_write_d = 1'b0;
                        cnt_d       = cnt_q + ONE_CENT;
                        cent_sel_d  = cnt_q + ONE_CENT;
                        state_d     = S_SELECT;
                    end
                end
            end
            S_STATUS: begin
                if (reg_ready) begin
                    reg_write_d = 1'b0;
                    irq_d       = 1'b1;
                    state_d     = S_IRQ;
                end
            end
            S_IRQ: begin
                if (irq_ack) begin
                    irq_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel drops any pending write; in IDLE a start takes precedence.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            reg_write_d = 1'b0;
            irq_d       = 1'b0;
            cnt_d       = '0;
            cent_sel_d  = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            conv_q      <= 1'b0;
            iter_q      <= '0;
            cent_sel_q  <= '0;
            reg_num_q   <= '0;
            reg_wdata_q <= '0;
            reg_write_q <= 1'b0;
            irq_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            conv_q      <= conv_d;
            iter_q      <= iter_d;
            cent_sel_q  <= cent_sel_d;
            reg_num_q   <= reg_num_d;
            reg_wdata_q <= reg_wdata_d;
            reg_write_q <= reg_write_d;
            irq_q       <= irq_d;
            busy_q      <= busy_d;
        end
    end

    assign cent_sel  = cent_sel_q;
    assign reg_num   = reg_num_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_write = reg_write_q;
    assign irq       = irq_q;
    assign busy      = busy_q;

endmodule

// File: doc/centroid_writeback_seq.md
Name: centroid_writeback_seq

Overview:
- Post-convergence writeback sequencer for the k-means core.
- Once the main controller reports convergence, this block reads the 8 final centroids one at a time from the classification block's centroid registers and writes each into the core register file.
- It then writes a status word (converged flag plus iteration count), raises an interrupt to the host, and holds it until acknowledged.
- It sits between the main controller, the classification block's centroid read mux, and the register-file write port.

Parameters:
centroid_num, 8, number of centroids to write back
log2_cent_num, 3, width of centroid index
dataWidth, 91, centroid word width (7 coords x 13 bits)
reg_amount, 4, register-file address width
cent_reg_base, 0, reg_num of centroid 0; centroid k goes to cent_reg_base+k
status_reg_addr, 8, reg_num of the status word
iter_cnt_width, 8, iteration counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  1-cycle pulse from controller: results ready
has_converged  in  1  converged flag, sampled with start
iter_count  in  iter_cnt_width  iterations executed, sampled with start
abort  in  1  synchronous cancel
cent_sel  out  log2_cent_num  centroid index to classification read mux
cent_data  in  dataWidth  centroid word for cent_sel, combinational, valid same cycle
reg_num  out  reg_amount  register-file write address
reg_wdata  out  dataWidth  register-file write data
reg_write  out  1  write request
reg_ready  in  1  register file accepts when reg_write & reg_ready
irq  out  1  results-ready interrupt, level
irq_ack  in  1  host acknowledge
busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: cent_sel=0, reg_num=0, reg_wdata=0, reg_write=0, irq=0, busy=0. Internal cnt=0, FSM=IDLE.
- FSM states: IDLE, SELECT, WRITE, STATUS, IRQ.
- IDLE:
  - On start: latch has_converged and iter_count, cnt<=0, cent_sel<=0, go to SELECT.
  - Otherwise stay.
- SELECT (1 cycle): cent_sel=cnt. At the cycle end:
  - reg_wdata<=cent_data
  - reg_num<=cent_reg_base+cnt (truncated to reg_amount bits)
  - reg_write<=1
  - go to WRITE
- WRITE: reg_write, reg_num and reg_wdata are held stable until reg_ready is sampled high. On acceptance:
  - If cnt==centroid_num-1: reg_num<=status_reg_addr, reg_wdata<={zeros, iter_count_latched, converged_latched} (bit0=converged, bits[iter_cnt_width:1]=iter_count), reg_write stays 1, go to STATUS.
  - Else: reg_write<=0, cnt<=cnt+1, cent_sel<=cnt+1, go to SELECT.
- STATUS: hold the write until reg_ready. On acceptance: reg_write<=0, irq<=1, go to IRQ.
- IRQ: irq held high until irq_ack is sampled. On ack: irq<=0, go to IDLE.
- Latency with reg_ready tied high, start sampled at edge 0:
  - centroid k written in cycle 2k+2 (WRITE)
  - status written in cycle 17
  - irq rises in cycle 18
  - an ack in cycle 18 returns the FSM to IDLE in cycle 19
- reg_ready low: stall indefinitely with no timeout. cent_data changes during WRITE are ignored because the data is already captured.
- start while busy: ignored; latched values are unchanged.
- irq_ack outside IRQ: ignored.
- abort (any state except IDLE): next cycle FSM=IDLE, reg_write=0, irq=0, cnt=0, cent_sel=0. A pending write is dropped and no status or irq is produced. If abort and start occur together in IDLE, start wins.
- Reset mid-operation: immediate return to reset values. No resume.
- cnt wrap: cnt never exceeds centroid_num-1.

Test Plan:
1. Nominal: reg_ready=1, start with has_converged=1, iter_count=8'd23; centroid k = 91'h100+k.
   - Required: writes (reg_num,data) = (0,0x100)...(7,0x107) in cycles 2,4,...,16; status (8, 91'd47) in cycle 17; irq=1 from cycle 18.
   - Ack in cycle 20 gives irq=0 and busy=0 in cycle 21.
2. Backpressure: reg_ready low for 5 cycles at centroid 3.
   - Required: reg_write=1, reg_num=3 and data stable for 6 cycles, with exactly one accepted write.
   - cent_data toggled during the stall does not alter reg_wdata. Total sequence is extended by 5 cycles.
3. Abort while in WRITE for centroid 5.
   - Required: next cycle reg_write=0, busy=0; irq is never asserted.
   - A following start restarts from centroid 0.
4. start pulsed during WRITE of centroid 2 with different iter_count=8'd99.
   - Required: ignored; status word still carries the original count.
5. Async rst_n asserted mid-STATUS (between clock edges).
   - Required: all outputs go to zero immediately.
   - After release, FSM stays in IDLE with no spurious reg_write or irq.
6. irq_ack held high from before start.
   - Required: irq is asserted for exactly 1 cycle, then the FSM returns to IDLE.
